// File: rtl/output_stage.sv
// De-skews four staggered segment lanes into one aligned, registered word; 1-4 enabled cycles per lane.
// No backpressure: i_en=0 freezes every lane, the valid pipe and the counter in lockstep.
module output_stage #(
  parameter int P_INPUT_WIDTH = 6,
  parameter int P_CNT_WIDTH   = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic                       i_vld,
  input  logic [P_INPUT_WIDTH-1:0]   i_lsb,
  input  logic [P_INPUT_WIDTH-1:0]   i_isb2,
  input  logic [P_INPUT_WIDTH-1:0]   i_isb1,
  input  logic [P_INPUT_WIDTH-1:0]   i_msb,
  output logic [P_INPUT_WIDTH-1:0]   o_msb,
  output logic [P_INPUT_WIDTH-1:0]   o_isb1,
  output logic [P_INPUT_WIDTH-1:0]   o_isb2,
  output logic [P_INPUT_WIDTH-1:0]   o_lsb,
  output logic [4*P_INPUT_WIDTH-1:0] o_word,
  output logic                       o_vld,
  output logic [P_CNT_WIDTH-1:0]     o_cnt
);

  logic [P_INPUT_WIDTH-1:0] lsb_sr [3];
  logic [P_INPUT_WIDTH-1:0] isb2_sr [2];
  logic [P_INPUT_WIDTH-1:0] isb1_sr;
  logic [2:0]               vld_sr;

  // Earlier lanes carry more delay so all four land on the output registers together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lsb_sr[0]  <= '0;
      lsb_sr[1]  <= '0;
      lsb_sr[2]  <= '0;
      isb2_sr[0] <= '0;
      isb2_sr[1] <= '0;
      isb1_sr    <= '0;
      vld_sr     <= '0;
      o_lsb      <= '0;
      o_isb2     <= '0;
      o_isb1     <= '0;
      o_msb      <= '0;
      o_vld      <= 1'b0;
      o_cnt      <= '0;
    end else if (i_en) begin
      lsb_sr[0]  <= i_lsb;
      lsb_sr[1]  <= lsb_sr[0];
      lsb_sr[2]  <= lsb_sr[1];
      isb2_sr[0] <= i_isb2;
      isb2_sr[1] <= isb2_sr[0];
      isb1_sr    <= i_isb1;
      vld_sr     <= {vld_sr[1:0], i_vld};
      o_lsb      <= lsb_sr[2];
      o_isb2     <= isb2_sr[1];
      o_isb1     <= isb1_sr;
      o_msb      <= i_msb;
      o_vld      <= vld_sr[2];
      if (vld_sr[2]) begin
        o_cnt <= o_cnt + 1'b1;
      end
    end
  end

  assign o_word = {o_msb, o_isb1, o_isb2, o_lsb};

endmodule

// File: tb/tb_output_stage.sv
// Directed bench for output_stage: lane-history model plus literal checks; two widths of counter.
module tb_output_stage;

  logic       clk;
  logic       rst, en, vld;
  logic [5:0] lsb, isb2, isb1, msb;

  logic [5:0]  a_msb, a_isb1, a_isb2, a_lsb;
  logic [23:0] a_word;
  logic        a_vld;
  logic [15:0] a_cnt;
  logic [5:0]  b_msb, b_isb1, b_isb2, b_lsb;
  logic [23:0] b_word;
  logic        b_vld;
  logic [3:0]  b_cnt;

  int n_chk = 0;
  int n_fail = 0;

  output_stage #(.P_INPUT_WIDTH(6), .P_CNT_WIDTH(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_vld(vld),
    .i_lsb(lsb), .i_isb2(isb2), .i_isb1(isb1), .i_msb(msb),
    .o_msb(a_msb), .o_isb1(a_isb1), .o_isb2(a_isb2), .o_lsb(a_lsb),
    .o_word(a_word), .o_vld(a_vld), .o_cnt(a_cnt)
  );

  output_stage #(.P_INPUT_WIDTH(6), .P_CNT_WIDTH(4)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_vld(vld),
    .i_lsb(lsb), .i_isb2(isb2), .i_isb1(isb1), .i_msb(msb),
    .o_msb(b_msb), .o_isb1(b_isb1), .o_isb2(b_isb2), .o_lsb(b_lsb),
    .o_word(b_word), .o_vld(b_vld), .o_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each lane is a history queue of the values seen on enabled edges;
  // the output shows lsb from 3 advances ago, isb2 from 2, isb1 from 1, msb now.
  logic [5:0] q_lsb[$], q_isb2[$], q_isb1[$];
  bit         q_vld[$];
  logic [5:0] e_lsb, e_isb2, e_isb1, e_msb;
  bit         e_vld;
  int         e_cnt;
  bit         model_ok = 0;

  always @(posedge clk) begin
    if (rst) begin
      q_lsb.delete(); q_isb2.delete(); q_isb1.delete(); q_vld.delete();
      repeat (3) begin q_lsb.push_back(6'd0); q_vld.push_back(1'b0); end
      repeat (2) q_isb2.push_back(6'd0);
      q_isb1.push_back(6'd0);
      e_lsb = 0; e_isb2 = 0; e_isb1 = 0; e_msb = 0; e_vld = 0; e_cnt = 0;
      model_ok = 1;
    end else if (en && model_ok) begin
      q_lsb.push_back(lsb); q_isb2.push_back(isb2); q_isb1.push_back(isb1); q_vld.push_back(vld);
      e_lsb  = q_lsb.pop_front();
      e_isb2 = q_isb2.pop_front();
      e_isb1 = q_isb1.pop_front();
      e_msb  = msb;
      e_vld  = q_vld.pop_front();
      if (e_vld) e_cnt++;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("word", 64'(a_word), 64'({e_msb, e_isb1, e_isb2, e_lsb}));
      check("lanes", 64'({a_msb, a_isb1, a_isb2, a_lsb}), 64'({e_msb, e_isb1, e_isb2, e_lsb}));
      check("vld", 64'(a_vld), 64'(e_vld));
      check("cnt", 64'(a_cnt), 64'(e_cnt & 16'hFFFF));
      check("word_w", 64'(b_word), 64'({e_msb, e_isb1, e_isb2, e_lsb}));
      check("vld_w", 64'(b_vld), 64'(e_vld));
      check("cnt_w", 64'(b_cnt), 64'(e_cnt & 4'hF));
    end
  end

  task automatic step(input bit r, input bit e, input bit v,
                      input logic [5:0] l, input logic [5:0] i2,
                      input logic [5:0] i1, input logic [5:0] m);
    rst = r; en = e; vld = v; lsb = l; isb2 = i2; isb1 = i1; msb = m;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1, 1, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [5:0] seg(input int k, input int lane);
    return 6'((k * 11 + lane * 17 + 3) & 63);
  endfunction

  int cnt_log [64];
  int vld_seen;

  // n words fed skewed; cnt_log[c] holds the narrow counter after step c.
  task automatic send_stream(input int n);
    vld_seen = 0;
    for (int c = 0; c < n + 5; c++) begin
      step(0, 1, c < n,
           (c < n) ? seg(c, 0) : 6'd0,
           (c >= 1 && c - 1 < n) ? seg(c - 1, 1) : 6'd0,
           (c >= 2 && c - 2 < n) ? seg(c - 2, 2) : 6'd0,
           (c >= 3 && c - 3 < n) ? seg(c - 3, 3) : 6'd0);
      if (a_vld) vld_seen++;
      cnt_log[c] = int'(b_cnt);
    end
  endtask

  bit mid_vld;

  initial begin
    rst = 1; en = 1; vld = 0; lsb = 0; isb2 = 0; isb1 = 0; msb = 0;

    // Reset held two cycles with random inputs.
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 1'($urandom), 6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom));
      check("rst_word", 64'(a_word), 64'd0);
      check("rst_vld", 64'(a_vld), 64'd0);
      check("rst_cnt", 64'(a_cnt), 64'd0);
    end

    // Single word.
    step(0, 1, 1, 6'h05, 0, 0, 0);
    step(0, 1, 0, 0, 6'h0A, 0, 0);
    step(0, 1, 0, 0, 0, 6'h15, 0);
    check("single_vld_early", 64'(a_vld), 64'd0);
    step(0, 1, 0, 0, 0, 0, 6'h2A);
    check("single_word", 64'(a_word), 64'hA95285);
    check("single_vld", 64'(a_vld), 64'd1);
    check("single_cnt", 64'(a_cnt), 64'd1);
    step(0, 1, 0, 0, 0, 0, 0);
    check("single_vld_drop", 64'(a_vld), 64'd0);
    check("single_cnt_hold", 64'(a_cnt), 64'd1);

    // Streaming 20 back-to-back words.
    do_reset();
    send_stream(20);
    check("stream_vld_cycles", 64'(vld_seen), 64'd20);
    check("stream_cnt", 64'(a_cnt), 64'd20);
    check("stream_cnt_w", 64'(b_cnt), 64'd4);

    // Stall of 3 cycles between isb2 and isb1 advances; junk inputs are ignored.
    do_reset();
    step(0, 1, 1, 6'h05, 0, 0, 0);
    step(0, 1, 0, 0, 6'h0A, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 6'h3F, 6'h3F, 6'h3F, 6'h3F);
      check("stall_vld", 64'(a_vld), 64'd0);
      check("stall_cnt", 64'(a_cnt), 64'd0);
    end
    step(0, 1, 0, 0, 0, 6'h15, 0);
    step(0, 1, 0, 0, 0, 0, 6'h2A);
    check("stall_word", 64'(a_word), 64'hA95285);
    check("stall_vld_out", 64'(a_vld), 64'd1);
    check("stall_cnt_out", 64'(a_cnt), 64'd1);
    step(0, 0, 0, 6'h11, 6'h22, 6'h33, 6'h04);
    check("hold_word", 64'(a_word), 64'hA95285);
    check("hold_vld", 64'(a_vld), 64'd1);

    // Reset mid-flight discards the word.
    do_reset();
    step(0, 1, 1, 6'h05, 0, 0, 0);
    step(0, 1, 0, 0, 6'h0A, 0, 0);
    step(1, 1, 0, 0, 0, 6'h15, 0);
    mid_vld = 0;
    step(0, 1, 0, 0, 0, 0, 6'h2A);
    if (a_vld) mid_vld = 1;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 0, 0, 0);
      if (a_vld) mid_vld = 1;
    end
    check("midrst_vld_seen", 64'(mid_vld), 64'd0);
    check("midrst_cnt", 64'(a_cnt), 64'd0);

    // Narrow counter wrap over 17 words.
    do_reset();
    send_stream(17);
    check("wrap_15", 64'(cnt_log[17]), 64'd15);
    check("wrap_0", 64'(cnt_log[18]), 64'd0);
    check("wrap_1", 64'(cnt_log[19]), 64'd1);
    check("wrap_wide", 64'(a_cnt), 64'd17);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
